uart_tx_arbiter: RTL and testbench

- Shares one UART transmit FIFO write port among cNumReq byte-stream requesters.
- Round-robin arbitration at packet granularity: a grant is held until the requester's last byte, or until cMaxLen bytes are sent, whichever comes first.
- Sits between on-chip message sources (status, debug, command response) and the TX FIFO feeding the UART transmitter.

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and the TX FIFO write port for uart_tx_arbiter.
// The arbiter takes the master modport; the requesters and FIFO side take the slave modport.
interface uart_tx_arbiter_if #(
    parameter int cNumReq = 4
);
    logic [cNumReq-1:0]   ReqValid;
    logic [8*cNumReq-1:0] ReqData;
    logic [cNumReq-1:0]   ReqLast;
    logic [cNumReq-1:0]   ReqReady;
    logic                 TxFfFull;
    logic                 TxFfWrEn;
    logic [7:0]           TxFfWrData;

    modport master (
        input  ReqValid, ReqData, ReqLast, TxFfFull,
        output ReqReady, TxFfWrEn, TxFfWrData
    );

    modport slave (
        output ReqValid, ReqData, ReqLast, TxFfFull,
        input  ReqReady, TxFfWrEn, TxFfWrData
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port among cNumReq requesters.
// Define UART_TX_ARB_HDR_EN to prefix every grant with the header byte cHdrBase|owner.
module uart_tx_arbiter #(
    parameter int         cNumReq  = 4,
    parameter int         cMaxLen  = 16,
    parameter logic [7:0] cHdrBase = 8'hA0
) (
    input  logic                  Clk,
    input  logic                  RstB,
    uart_tx_arbiter_if.master     bus,
    output logic [cNumReq-1:0]    Grant,
    output logic                  Busy
);
    localparam int cIdxW = (cNumReq > 1) ? $clog2(cNumReq) : 1;
    localparam int cSumW = cIdxW + 1;

    if (cNumReq < 2 || cNumReq > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: cNumReq must be 2..8");
    end
    if (cMaxLen < 1 || cMaxLen > 255) begin : g_bad_max_len
        $error("uart_tx_arbiter: cMaxLen must be 1..255");
    end
    // The owner index is ORed into the low three header bits, so they must be free.
    if (cHdrBase[2:0] != 3'b000) begin : g_bad_hdr_base
        $error("uart_tx_arbiter: cHdrBase[2:0] must be zero");
    end

    typedef enum logic [1:0] {
        stIdle = 2'd0,
`ifdef UART_TX_ARB_HDR_EN
        stHdr  = 2'd2,
`endif
        stXfer = 2'd1
    } state_t;

    state_t             state_q;
    logic [cNumReq-1:0] grant_q;
    logic               busy_q;
    logic [cIdxW-1:0]   ptr_q;
    logic [cIdxW-1:0]   gidx_q;
    logic [7:0]         len_cnt_q;

    logic               any_valid_d;
    logic [cIdxW-1:0]   sel_idx_d;
    logic [cIdxW-1:0]   ptr_d;
    logic [7:0]         len_cnt_d;
    logic               xfer_d;
    logic               release_d;
    logic [cNumReq-1:0] req_ready_d;
    logic               wr_en_d;
    logic [7:0]         wr_data_d;

    // Round-robin search: the lowest offset from ptr_q with a valid byte wins.
    always_comb begin
        logic [cSumW-1:0] sum;
        logic [cIdxW-1:0] cand;
        any_valid_d = 1'b0;
        sel_idx_d   = ptr_q;
        for (int k = cNumReq - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + cSumW'(k);
            if (sum >= cSumW'(cNumReq)) begin
                sum = sum - cSumW'(cNumReq);
            end
            cand = sum[cIdxW-1:0];
            if (bus.ReqValid[cand]) begin
                any_valid_d = 1'b1;
                sel_idx_d   = cand;
            end
        end
    end

    assign ptr_d     = (gidx_q == cIdxW'(cNumReq - 1)) ? '0 : gidx_q + cIdxW'(1);
    assign len_cnt_d = len_cnt_q + 8'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        req_ready_d = '0;
        wr_en_d     = 1'b0;
        wr_data_d   = 8'h00;
        xfer_d      = 1'b0;
        if (!RstB) begin
            case (state_q)
                stXfer: begin
                    req_ready_d[gidx_q] = !bus.TxFfFull;
                    if (bus.ReqValid[gidx_q] && !bus.TxFfFull) begin
                        xfer_d    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_data_d = bus.ReqData[{gidx_q, 3'b000} +: 8];
                    end
                end
`ifdef UART_TX_ARB_HDR_EN
                stHdr: begin
                    if (!bus.TxFfFull) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = cHdrBase | 8'(gidx_q);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Last byte and the cMaxLen limit on the same transfer are a single release.
    assign release_d = xfer_d && (bus.ReqLast[gidx_q] || len_cnt_d == 8'(cMaxLen));

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RstB) begin
            state_q   <= stIdle;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            gidx_q    <= '0;
            len_cnt_q <= '0;
        end else begin
            case (state_q)
                stIdle: begin
                    if (any_valid_d) begin
                        gidx_q    <= sel_idx_d;
                        grant_q   <= cNumReq'(1) << sel_idx_d;
                        len_cnt_q <= '0;
                        busy_q    <= 1'b1;
`ifdef UART_TX_ARB_HDR_EN
                        state_q   <= stHdr;
`else
                        state_q   <= stXfer;
`endif
                    end
                end
`ifdef UART_TX_ARB_HDR_EN
                stHdr: begin
                    if (!bus.TxFfFull) begin
                        state_q <= stXfer;
                    end
                end
`endif
                stXfer: begin
                    if (xfer_d) begin
                        len_cnt_q <= len_cnt_d;
                        if (release_d) begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            ptr_q   <= ptr_d;
                            state_q <= stIdle;
                        end
                    end
                end
                default: state_q <= stIdle;
            endcase
        end
    end

    assign bus.ReqReady   = req_ready_d;
    assign bus.TxFfWrEn   = wr_en_d;
    assign bus.TxFfWrData = wr_data_d;
    assign Grant          = grant_q;
    assign Busy           = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a packet-level reference model compared every cycle,
// plus directed scenarios whose FIFO byte streams and grant orders are written out by hand.
module tb_uart_tx_arbiter;
    localparam int N      = 4;
    localparam int MAXLEN = 4;
`ifdef UART_TX_ARB_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic         Clk  = 1'b0;
    logic         RstB = 1'b1;
    logic [N-1:0] Grant;
    logic         Busy;

    always #5 Clk = ~Clk;

    uart_tx_arbiter_if #(.cNumReq(N)) bus ();

    uart_tx_arbiter #(
        .cNumReq (N),
        .cMaxLen (MAXLEN),
        .cHdrBase(8'hA0)
    ) dut (
        .Clk  (Clk),
        .RstB (RstB),
        .bus  (bus),
        .Grant(Grant),
        .Busy (Busy)
    );

    beat_t src_q[N][$];
    logic  ff_full = 1'b0;
    int    checks  = 0;
    int    errors  = 0;
    bit    chk_en  = 1'b0;
    int    cyc     = 0;

    logic [7:0]   wr_log[$];
    int           wr_cyc[$];
    logic [N-1:0] gnt_log[$];
    int           gnt_cyc[$];
    logic [N-1:0] prev_grant = '0;
    logic [7:0]   exp_q[$];

    // Reference model: who owns the port, where the next search starts, bytes in this grant.
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_cnt   = 0;
    bit           m_hdr   = 1'b0;
    logic [N-1:0] m_acc   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                bus.ReqValid[i]      = 1'b1;
                bus.ReqData[8*i +: 8] = src_q[i][0].data;
                bus.ReqLast[i]       = src_q[i][0].last;
            end else begin
                bus.ReqValid[i]      = 1'b0;
                bus.ReqData[8*i +: 8] = 8'h00;
                bus.ReqLast[i]       = 1'b0;
            end
        end
        bus.TxFfFull = ff_full;
    endtask

    task automatic push_seq(input int r, input logic [7:0] first, input logic [7:0] step,
                            input int n, input bit last_at_end);
        logic [7:0] v;
        v = first;
        for (int i = 0; i < n; i++) begin
            src_q[r].push_back('{data: v, last: (last_at_end && i == n - 1)});
            v = v + step;
        end
    endtask

    task automatic sync();
        @(posedge Clk);
        #2;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        gnt_log.delete();
        gnt_cyc.delete();
        exp_q.delete();
    endtask

    task automatic exp_hdr(input int g);
`ifdef UART_TX_ARB_HDR_EN
        exp_q.push_back(8'hA0 | 8'(g));
`else
        if (g < 0) exp_q.push_back(8'h00);
`endif
    endtask

    task automatic exp_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check($sformatf("%s_byte%0d", name, i), wr_log[i], exp_q[i]);
    endtask

    task automatic drain(input string name, input int budget);
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < budget) begin
            sync();
            n++;
            pending = (m_owner >= 0);
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pending = 1'b1;
        end
        check({name, "_drain_in_budget"}, pending, 1'b0);
        sync();
        sync();
    endtask

    task automatic do_reset();
        sync();
        RstB = 1'b1;
        sync();
        sync();
        chk_en = 1'b1;
        RstB   = 1'b0;
    endtask

    always @(posedge Clk) begin
        int           o, p, c;
        bit           h;
        logic [N-1:0] acc;
        o   = m_owner;
        p   = m_ptr;
        c   = m_cnt;
        h   = m_hdr;
        acc = '0;
        if (RstB) begin
            o = -1;
            p = 0;
            c = 0;
            h = 1'b0;
        end else if (o < 0) begin
            for (int k = 0; k < N; k++)
                if (o < 0 && bus.ReqValid[(p + k) % N]) o = (p + k) % N;
            if (o >= 0) begin
                c = 0;
                h = (HDR != 0);
            end
        end else if (h) begin
            if (!bus.TxFfFull) h = 1'b0;
        end else if (bus.ReqValid[o] && !bus.TxFfFull) begin
            acc[o] = 1'b1;
            c++;
            if (bus.ReqLast[o] || c == MAXLEN) begin
                p = (o + 1) % N;
                o = -1;
            end
        end
        m_owner <= o;
        m_ptr   <= p;
        m_cnt   <= c;
        m_hdr   <= h;
        m_acc   <= acc;
    end

    // Requesters: drop a byte once the model says it was taken, then present the next one.
    always @(posedge Clk) begin
        #1;
        for (int i = 0; i < N; i++)
            if (m_acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive_inputs();
    end

    always @(negedge Clk) begin
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic         e_wr;
        logic [7:0]   e_data;
        cyc++;
        if (chk_en) begin
            e_grant = '0;
            e_ready = '0;
            e_wr    = 1'b0;
            e_data  = 8'h00;
            if (m_owner >= 0) e_grant[m_owner] = 1'b1;
            if (!RstB && m_owner >= 0 && !bus.TxFfFull) begin
                if (m_hdr) begin
                    e_wr   = 1'b1;
                    e_data = 8'hA0 | 8'(m_owner);
                end else begin
                    e_ready[m_owner] = 1'b1;
                    if (bus.ReqValid[m_owner]) begin
                        e_wr   = 1'b1;
                        e_data = bus.ReqData[8*m_owner +: 8];
                    end
                end
            end
            check("grant", Grant, e_grant);
            check("busy", Busy, m_owner >= 0);
            check("req_ready", bus.ReqReady, e_ready);
            check("wr_en", bus.TxFfWrEn, e_wr);
            check("wr_data", bus.TxFfWrData, e_data);
            if (Grant !== prev_grant && Grant != '0) begin
                gnt_log.push_back(Grant);
                gnt_cyc.push_back(cyc);
            end
            if (bus.TxFfWrEn === 1'b1) begin
                wr_log.push_back(bus.TxFfWrData);
                wr_cyc.push_back(cyc);
            end
            prev_grant = Grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        drive_inputs();
        do_reset();

        // 1: single 3-byte packet from requester 2.
        clear_logs();
        sync();
        push_seq(2, 8'h11, 8'h11, 3, 1'b1);
        drive_inputs();
        @(negedge Clk);
        check("t1_grant_while_requesting", Grant, 4'b0000);
        sync();
        @(negedge Clk);
        check("t1_grant_one_cycle_later", Grant, 4'b0100);
        drain("t1", 50);
        exp_hdr(2);
        exp_bytes(8'h11, 1);
        exp_bytes(8'h22, 1);
        exp_bytes(8'h33, 1);
        check_stream("t1");
        n = wr_cyc.size();
        if (n >= 3) check("t1_back_to_back", wr_cyc[n-1] - wr_cyc[n-3], 2);
        check("t1_ptr_after", m_ptr, 3);

        // 2: two 1-byte packets per requester, round-robin twice.
        do_reset();
        clear_logs();
        sync();
        for (int r = 0; r < N; r++) begin
            push_seq(r, 8'hB0 + 8'(r), 8'h00, 1, 1'b1);
            push_seq(r, 8'hC0 + 8'(r), 8'h00, 1, 1'b1);
        end
        drive_inputs();
        drain("t2", 100);
        for (int r = 0; r < N; r++) begin
            exp_hdr(r);
            exp_bytes(8'hB0 + 8'(r), 1);
        end
        for (int r = 0; r < N; r++) begin
            exp_hdr(r);
            exp_bytes(8'hC0 + 8'(r), 1);
        end
        check_stream("t2");
        check("t2_grant_count", gnt_log.size(), 8);
        for (int i = 0; i < gnt_log.size(); i++)
            check($sformatf("t2_grant%0d", i), gnt_log[i], 4'b0001 << (i % 4));
        for (int i = 1; i < gnt_cyc.size(); i++)
            check($sformatf("t2_spacing%0d", i), gnt_cyc[i] - gnt_cyc[i-1], 2 + HDR);

        // 3: FIFO full for 5 cycles in the middle of a 4-byte packet.
        do_reset();
        clear_logs();
        sync();
        push_seq(1, 8'h31, 8'h01, 4, 1'b1);
        drive_inputs();
        n = 0;
        while (src_q[1].size() != 2 && n < 20) begin
            sync();
            n++;
        end
        check("t3_two_bytes_sent", src_q[1].size(), 2);
        ff_full = 1'b1;
        drive_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check($sformatf("t3_full_ready%0d", i), bus.ReqReady, 4'b0000);
            check($sformatf("t3_full_wren%0d", i), bus.TxFfWrEn, 1'b0);
            sync();
        end
        ff_full = 1'b0;
        drive_inputs();
        drain("t3", 50);
        exp_hdr(1);
        exp_bytes(8'h31, 4);
        check_stream("t3");
        check("t3_ptr_after", m_ptr, 2);

        // 4: requester 0 streams 10 bytes and is cut at MAXLEN while requester 1 waits.
        do_reset();
        clear_logs();
        sync();
        push_seq(0, 8'h40, 8'h01, 10, 1'b1);
        push_seq(1, 8'h81, 8'h00, 1, 1'b1);
        drive_inputs();
        drain("t4", 200);
        exp_hdr(0);
        exp_bytes(8'h40, 4);
        exp_hdr(1);
        exp_bytes(8'h81, 1);
        exp_hdr(0);
        exp_bytes(8'h44, 4);
        exp_hdr(0);
        exp_bytes(8'h48, 2);
        check_stream("t4");
        check("t4_grant_count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            check("t4_grant0", gnt_log[0], 4'b0001);
            check("t4_grant1", gnt_log[1], 4'b0010);
            check("t4_grant2", gnt_log[2], 4'b0001);
            check("t4_grant3", gnt_log[3], 4'b0001);
        end

        // 5: reset after 2 of 5 bytes; requester 1 then wins from pointer 0.
        do_reset();
        clear_logs();
        sync();
        push_seq(2, 8'h21, 8'h01, 5, 1'b1);
        drive_inputs();
        n = 0;
        while (src_q[2].size() != 3 && n < 20) begin
            sync();
            n++;
        end
        check("t5_two_bytes_sent", src_q[2].size(), 3);
        push_seq(1, 8'h91, 8'h00, 1, 1'b1);
        RstB = 1'b1;
        drive_inputs();
        sync();
        RstB = 1'b0;
        @(negedge Clk);
        check("t5_grant_after_reset", Grant, 4'b0000);
        check("t5_busy_after_reset", Busy, 1'b0);
        check("t5_wren_after_reset", bus.TxFfWrEn, 1'b0);
        sync();
        @(negedge Clk);
        check("t5_lowest_wins", Grant, 4'b0010);
        drain("t5", 80);
        exp_hdr(2);
        exp_bytes(8'h21, 2);
        exp_hdr(1);
        exp_bytes(8'h91, 1);
        exp_hdr(2);
        exp_bytes(8'h23, 3);
        check_stream("t5");

        // 6: single byte from requester 3 (header 0xA3 first when headers are enabled).
        do_reset();
        clear_logs();
        sync();
        push_seq(3, 8'h55, 8'h00, 1, 1'b1);
        drive_inputs();
        drain("t6", 30);
        exp_hdr(3);
        exp_bytes(8'h55, 1);
        check_stream("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
